// File: rtl/hack_io_pkg.sv
// rtl/hack_io_pkg.sv - shared types, constants and helpers for the HACK output UART
package hack_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Clock cycles per serial bit, truncated toward zero.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with restart and one-cycle bit_done
module uart_bit_timer #(
    parameter int DIV = 434
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: restart wins, otherwise wrap at the last cycle of the bit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = (cnt_q == LAST);

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - serialises every new HACK output word onto a UART line
module mmio_uart_tx
    import hack_io_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int DW     = 16
) (
    input  logic          rst_n,
    input  logic          clk50m,
    input  logic [DW-1:0] word_in,
    output logic          tx,
    output logic          busy,
    output logic          overrun
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int NB  = DW / 8;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

    tx_state_t     state_q, state_d;
    logic [DW-1:0] last_seen_q;
    logic [DW-1:0] pend_word_q, pend_word_d;
    logic          pend_valid_q, pend_valid_d;
    logic [DW-1:0] word_q, word_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic          tx_q, tx_d;
    logic          overrun_q, overrun_d;
    logic          change;
    logic          consume;
    logic          restart;
    logic          bit_done;

    uart_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .restart_i  (restart),
        .bit_done_o (bit_done)
    );

    // Frame sequencing; tx is computed from the next state so it changes on the same edge.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_d     = byte_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        consume    = 1'b0;
        tx_d       = 1'b1;
        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    consume    = 1'b1;
                    word_d     = pend_word_q;
                    byte_idx_d = BW'(NB - 1);
                    state_d    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    byte_d    = word_q[8*byte_idx_q +: 8];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        byte_d    = byte_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_idx_q != '0) begin
                        byte_idx_d = byte_idx_q - BW'(1);
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[0];
            default: tx_d = 1'b1;
        endcase
        restart = (state_d != state_q) || (state_q == IDLE);
    end

    // Latest-value buffer: a change always wins, a consume alone empties it.
    always_comb begin
        change       = (word_in != last_seen_q);
        pend_word_d  = pend_word_q;
        pend_valid_d = pend_valid_q;
        if (change) begin
            pend_word_d  = word_in;
            pend_valid_d = 1'b1;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
        overrun_d = change && pend_valid_q && !consume;
    end

    // State, shift and buffer registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_seen_q  <= '0;
            pend_word_q  <= '0;
            pend_valid_q <= 1'b0;
            word_q       <= '0;
            byte_q       <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            tx_q         <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_seen_q  <= word_in;
            pend_word_q  <= pend_word_d;
            pend_valid_q <= pend_valid_d;
            word_q       <= word_d;
            byte_q       <= byte_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            tx_q         <= tx_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx      = tx_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != IDLE) || pend_valid_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam int DIV   = 4;
    localparam int NB    = 2;
    localparam int FRAME = NB * 10 * DIV;

    logic        clk50m = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] word_in = 16'h0000;
    logic        tx, busy, overrun;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [15:0] m_last, m_pw, m_frame;
    logic        m_pv, m_active, m_ovr;
    int          m_pos;
    logic [15:0] m_sent[$];

    // per-cycle tracking counters
    int mism_tx, mism_busy, mism_ovr, ovr_pulses;

    // line decoder
    logic [7:0] rx_q[$];
    logic       rx_act;
    int         rx_t;
    logic [7:0] rx_b;

    mmio_uart_tx #(
        .CLK_HZ (400),
        .BAUD   (100),
        .DW     (16)
    ) dut (
        .rst_n   (rst_n),
        .clk50m  (clk50m),
        .word_in (word_in),
        .tx      (tx),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk50m = ~clk50m;

    function automatic logic frame_bit(input logic [15:0] w, input int i);
        int b, r;
        logic [15:0] t;
        logic [7:0] by;
        b  = i / 10;
        r  = i % 10;
        t  = w >> (8 * (NB - 1 - b));
        by = t[7:0];
        if (r == 0) return 1'b0;
        if (r == 9) return 1'b1;
        return by[r-1];
    endfunction

    task automatic model_reset();
        m_last = 16'h0; m_pw = 16'h0; m_frame = 16'h0;
        m_pv = 1'b0; m_active = 1'b0; m_ovr = 1'b0; m_pos = 0;
    endtask

    task automatic clear_track();
        mism_tx = 0; mism_busy = 0; mism_ovr = 0; ovr_pulses = 0;
        rx_q.delete(); m_sent.delete();
    endtask

    // One clock: drive word, advance the model, sample the DUT and decode the line.
    task automatic step(input logic [15:0] w);
        logic chg, cons, exp_tx;
        word_in = w;
        @(posedge clk50m);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            chg   = (w != m_last);
            cons  = !m_active && m_pv;
            m_ovr = chg && m_pv && !cons;
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) m_active = 1'b0;
            end
            if (cons) begin
                m_frame = m_pw; m_pos = 0; m_active = 1'b1;
                m_sent.push_back(m_pw);
            end
            if (chg) begin
                m_pw = w; m_pv = 1'b1;
            end else if (cons) begin
                m_pv = 1'b0;
            end
            m_last = w;
        end
        exp_tx = m_active ? frame_bit(m_frame, m_pos / DIV) : 1'b1;
        if (tx !== exp_tx) mism_tx++;
        if (busy !== (m_active | m_pv)) mism_busy++;
        if (overrun !== m_ovr) mism_ovr++;
        if (overrun === 1'b1) ovr_pulses++;
        if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1; rx_t = 0; rx_b = 8'h00;
            end
        end else begin
            rx_t++;
            if ((rx_t % DIV == DIV / 2) && (rx_t / DIV >= 1) && (rx_t / DIV <= 8))
                rx_b[rx_t/DIV-1] = tx;
            if (rx_t == 9 * DIV + DIV / 2) begin
                rx_q.push_back(rx_b);
                rx_act = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        clear_track();
        model_reset();
        rx_act = 1'b0;
        rst_n = 1'b0;
        word_in = 16'h0000;
        repeat (3) @(posedge clk50m);
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs tx=%b busy=%b overrun=%b required tx=1 busy=0 overrun=0", tx, busy, overrun);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) step(16'h0000);
        checks++;
        if (mism_tx + mism_busy + mism_ovr !== 0) begin
            failures++;
            $display("FAIL reset_idle tx/busy/ovr mismatches=%0d/%0d/%0d required 0", mism_tx, mism_busy, mism_ovr);
        end
        checks++;
        if (rx_q.size() !== 0 || rx_act !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_start bytes=%0d active=%b required 0 bytes", rx_q.size(), rx_act);
        end
    endtask

    task automatic test_single_word();
        clear_track();
        step(16'hA55A);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_edge tx=%b busy=%b required tx=1 busy=1", tx, busy);
        end
        step(16'hA55A);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL start_latency tx=%b required 0", tx);
        end
        for (int i = 0; i < 85; i++) step(16'hA55A);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_end busy=%b required 0", busy);
        end
        checks++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h5A) begin
            failures++;
            $display("FAIL a55a_bytes count=%0d first=%h required 2 bytes a5 5a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
        checks++;
        if (mism_tx + mism_busy + mism_ovr + ovr_pulses !== 0) begin
            failures++;
            $display("FAIL a55a_track tx/busy/ovr/pulses=%0d/%0d/%0d/%0d required 0", mism_tx, mism_busy, mism_ovr, ovr_pulses);
        end
    endtask

    task automatic test_rewrite();
        clear_track();
        for (int i = 0; i < 500; i++) step(16'hA55A);
        checks++;
        if (rx_q.size() !== 0 || mism_busy !== 0 || mism_tx !== 0) begin
            failures++;
            $display("FAIL rewrite_silent bytes=%0d busy_mism=%0d tx_mism=%0d required 0", rx_q.size(), mism_busy, mism_tx);
        end
    endtask

    task automatic test_overrun();
        logic seen_idle, gap;
        clear_track();
        seen_idle = 1'b0;
        gap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(16'h1234);
            if (busy !== 1'b1) gap = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            step(16'h1111);
            if (busy !== 1'b1) gap = 1'b1;
        end
        for (int i = 0; i < 220; i++) begin
            step(16'h2222);
            if (busy === 1'b0) seen_idle = 1'b1;
            else if (seen_idle) gap = 1'b1;
        end
        checks++;
        if (ovr_pulses !== 1 || mism_ovr !== 0) begin
            failures++;
            $display("FAIL overrun_pulses pulses=%0d timing_mism=%0d required 1 and 0", ovr_pulses, mism_ovr);
        end
        checks++;
        if (rx_q.size() !== 4 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34 || rx_q[2] !== 8'h22 || rx_q[3] !== 8'h22) begin
            failures++;
            $display("FAIL overrun_bytes count=%0d required 12 34 22 22", rx_q.size());
        end
        checks++;
        if (gap !== 1'b0 || seen_idle !== 1'b1 || mism_tx !== 0) begin
            failures++;
            $display("FAIL overrun_busy gap=%b idle_seen=%b tx_mism=%0d required 0 1 0", gap, seen_idle, mism_tx);
        end
    endtask

    task automatic test_consume_collision();
        clear_track();
        step(16'h00FF);
        step(16'hFF00);
        for (int i = 0; i < 200; i++) step(16'hFF00);
        checks++;
        if (rx_q.size() !== 4 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF || rx_q[2] !== 8'hFF || rx_q[3] !== 8'h00) begin
            failures++;
            $display("FAIL collision_bytes count=%0d required 00 ff ff 00", rx_q.size());
        end
        checks++;
        if (ovr_pulses !== 0 || mism_tx + mism_busy + mism_ovr !== 0) begin
            failures++;
            $display("FAIL collision_track pulses=%0d mism=%0d required 0", ovr_pulses, mism_tx + mism_busy + mism_ovr);
        end
    endtask

    task automatic test_reset_midframe();
        clear_track();
        for (int i = 0; i < 16; i++) step(16'hBEEF);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL async_reset tx=%b busy=%b overrun=%b required 1 0 0", tx, busy, overrun);
        end
        model_reset();
        rx_act = 1'b0;
        rx_q.delete();
        m_sent.delete();
        mism_tx = 0; mism_busy = 0; mism_ovr = 0;
        for (int i = 0; i < 3; i++) step(16'hBEEF);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step(16'hBEEF);
        checks++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'hBE || rx_q[1] !== 8'hEF) begin
            failures++;
            $display("FAIL restart_bytes count=%0d required be ef", rx_q.size());
        end
        checks++;
        if (mism_tx + mism_busy + mism_ovr !== 0) begin
            failures++;
            $display("FAIL restart_track tx/busy/ovr=%0d/%0d/%0d required 0", mism_tx, mism_busy, mism_ovr);
        end
    endtask

    task automatic test_random();
        logic [15:0] pool[4];
        logic [15:0] w;
        int n, bad;
        clear_track();
        for (int i = 0; i < 4; i++) pool[i] = 16'($urandom);
        w = pool[0];
        for (int cyc = 0; cyc < 4000; cyc += n) begin
            w = pool[$urandom_range(0, 3)];
            n = $urandom_range(1, 120);
            for (int k = 0; k < n; k++) step(w);
        end
        for (int k = 0; k < 200; k++) step(w);
        checks++;
        if (mism_tx + mism_busy + mism_ovr !== 0) begin
            failures++;
            $display("FAIL random_track tx/busy/ovr=%0d/%0d/%0d required 0", mism_tx, mism_busy, mism_ovr);
        end
        bad = 0;
        if (rx_q.size() != 2 * m_sent.size()) begin
            bad = 1;
        end else begin
            for (int i = 0; i < m_sent.size(); i++)
                if ({rx_q[2*i], rx_q[2*i+1]} !== m_sent[i]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL random_stream bytes=%0d words=%0d bad=%0d required 0", rx_q.size(), m_sent.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_rewrite();
        test_overrun();
        test_consume_collision();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Downstream consumer of the HACK memory-mapped output register. It watches the register's 16-bit output word and serialises every new value onto a UART TX line, high byte first, so host software can log HACK output. A single-entry latest-value buffer decouples the CPU's write rate from the serial rate.

Parameters:
CLK_HZ, 50_000_000, clock frequency in Hz
BAUD, 115_200, serial bit rate; bit period DIV = CLK_HZ/BAUD cycles (integer truncation, 434 by default; DIV >= 2 required)
DW, 16, watched word width; must be a multiple of 8; NB = DW/8 bytes per word

Ports:
rst_n  input  1  asynchronous active-low reset
clk50m  input  1  system clock
word_in  input  DW  output-register word (synchronous to clk50m)
tx  output  1  UART serial line, idle high
busy  output  1  high while a word is pending or in transmission
overrun  output  1  one-cycle pulse when an unsent pending word is overwritten

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, overrun=0, FSM=IDLE, pend_valid=0, last_seen=0, all counters 0. Reset mid-frame aborts immediately: tx high, pending word discarded.
- Change detect: last_seen <= word_in every cycle. At an edge where word_in != last_seen: pend_word <= word_in, pend_valid <= 1. Rewriting an identical value is invisible and sends nothing. After reset, a nonzero word_in therefore triggers one transmission.
- Overrun: a change at an edge where pend_valid=1 and the FSM does not consume the pending word on that edge pulses overrun for 1 cycle. The newer word replaces the older (latest-value semantics).
- Simultaneous consume and change at the same edge: the FSM takes the old pend_word and pend_valid stays 1 with the new word. No overrun.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if pend_valid, load shift word <= pend_word, clear pend_valid, byte_idx <= NB-1, go to START.
  - START: tx=0 for DIV cycles, then load byte = word[8*byte_idx+:8] and go to DATA.
  - DATA: 8 bits, LSB first, each DIV cycles, then go to STOP.
  - STOP: tx=1 for DIV cycles. Then, if byte_idx != 0, decrement and go to START (no extra idle). Otherwise go to IDLE.
- tx is driven from a register (glitch-free).
- Bit timer: counts 0..DIV-1. A bit ends when the count reaches DIV-1. The timer restarts on every state entry.
- Latency: a word first sampled at edge k gives pend_valid at k. tx falls at edge k+1 if the FSM is IDLE.
- Frame length per word: NB*10*DIV cycles (8680 at the defaults).
- busy = (state != IDLE) | pend_valid, registered-equivalent with no combinational path from word_in.
- Arithmetic: bit counter 3 bits, byte_idx $clog2(NB) bits (minimum 1), timer $clog2(DIV) bits. Counters never wrap unintentionally; each is reset on state entry.

Decomposition:
- Package hack_io_pkg holds:
  - the state typedef tx_state_t (IDLE, START, DATA, STOP)
  - the function baud_div(clk_hz, baud)
  - the constants UART_DATA_BITS=8 and UART_STOP_BITS=1
- One sub-module, uart_bit_timer: counts to DIV-1 with a restart input and emits a one-cycle bit_done pulse. The FSM, change detection and buffer stay in mmio_uart_tx.

Test Plan:
(Benches use CLK_HZ=400, BAUD=100, so DIV=4 and a 16-bit word takes 80 cycles.)
1. Reset with word_in=0x0000 held for 200 cycles -> tx=1, busy=0, overrun=0 throughout; no start bit.
2. word_in 0x0000->0xA55A -> tx low 2 edges after the change. Line carries 0 10100101(LSB first of 0xA5) 1 0 01011010(LSB first of 0x5A) 1, each bit 4 cycles. busy falls after 80 cycles. No overrun.
3. word_in stays at 0xA55A (rewritten) for 500 cycles after scenario 2 -> no further frames.
4. While 0x1234 is transmitting, change to 0x1111 then 0x2222 -> exactly one overrun pulse (at the 0x2222 edge). Decoded stream is 0x12,0x34,0x22,0x22; 0x1111 is never sent. busy stays high continuously.
5. Change word_in on the exact edge where IDLE consumes pend_word (0x00FF then 0xFF00) -> 0x00FF sent, then 0xFF00. No overrun.
6. Assert rst_n mid-DATA of 0xBEEF, release with word_in=0xBEEF -> tx=1 immediately on reset. After release a full 0xBEEF frame restarts from the start bit, because last_seen reset to 0.
